// File: rtl/lr35902_pkg.sv
// Shared LR35902 bus constants and types for the OAM DMA engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lr35902_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADR   = 16'hFF46;
    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam int          OAM_LEN       = 160;
    localparam logic [15:0] HRAM_IO_BASE  = 16'hFF00;
    localparam logic [7:0]  DMA_ECHO_MASK = 8'hDF;

    // Source pages 0xE0-0xFF are echo RAM; fold them back onto WRAM 0xC0-0xDF.
    function automatic logic [7:0] dma_src_page(input logic [7:0] v);
        return (v >= 8'hE0) ? (v & DMA_ECHO_MASK) : v;
    endfunction

endpackage

// File: rtl/lr35902_oam_dma.sv
// OAM DMA: a CPU write to REG_ADR copies LEN bytes from {src,8'h00} into OAM.
// Latency: write at clk T, first ce ends START, each later ce moves one byte.
// Backpressure: ce low freezes the engine; a register write restarts it at any time.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   ce                    one-clk strobe per machine cycle, paces the transfer
//   cpu_adr/cpu_wr/cpu_din CPU bus write port (register decode happens here)
//   dma_reg               last value written to REG_ADR (readback)
//   dma_active, bus_dma   transfer pending/running, DMA owns the source bus
//   dma_adr, bus_data     source address and the byte returned for it
//   oam_adr/oam_wdata/oam_we OAM write port
//   cpu_block             current CPU access must be ignored (reads as 8'hFF)
module lr35902_oam_dma
    import lr35902_pkg::*;
#(
    parameter int          LEN     = OAM_LEN,
    parameter logic [15:0] REG_ADR = DMA_REG_ADR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] cpu_adr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  dma_reg,
    output logic        dma_active,
    output logic        bus_dma,
    output logic [15:0] dma_adr,
    input  logic [7:0]  bus_data,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        cpu_block
);

    // With LEN==256 this is 8'hFF, so the 8-bit index never wraps.
    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    dma_state_t  state_q;
    logic [7:0]  idx_q;
    logic [7:0]  src_q;
    logic [7:0]  src_d;
    logic [7:0]  dma_reg_q;
    logic        reg_wr;
    logic        in_xfer;

    // Register decode is independent of ce so a write is never missed.
    assign reg_wr  = cpu_wr && (cpu_adr == REG_ADR);
    assign src_d   = dma_src_page(cpu_din);
    assign in_xfer = (state_q == XFER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 8'h00;
            src_q     <= 8'h00;
            dma_reg_q <= 8'h00;
        end else if (reg_wr) begin
            // A write in any state (re)starts the transfer from byte 0.
            dma_reg_q <= cpu_din;
            src_q     <= src_d;
            idx_q     <= 8'h00;
            state_q   <= START;
        end else if (ce) begin
            unique case (state_q)
                START: begin
                    state_q <= XFER;
                    idx_q   <= 8'h00;
                end
                XFER: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        idx_q   <= 8'h00;
                    end else begin
                        idx_q <= idx_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dma_reg    = dma_reg_q;
    assign dma_active = (state_q != IDLE);
    assign bus_dma    = in_xfer;
    assign dma_adr    = in_xfer ? {src_q, idx_q} : 16'h0000;
    assign oam_adr    = in_xfer ? idx_q : 8'h00;
    assign oam_wdata  = bus_data;
    // A coinciding register write wins: the byte is dropped and the restart taken.
    assign oam_we     = ce && in_xfer && !reg_wr;
    // I/O and HRAM stay reachable so the CPU can poll or restart the DMA.
    assign cpu_block  = in_xfer && (cpu_adr < HRAM_IO_BASE);

endmodule

// File: tb/tb_lr35902_oam_dma.sv
module tb_lr35902_oam_dma;
    import lr35902_pkg::*;

    localparam int LEN = 160;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ce, cpu_wr;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_din, bus_data;
    logic [7:0]  dma_reg, oam_adr, oam_wdata;
    logic        dma_active, bus_dma, oam_we, cpu_block;
    logic [15:0] dma_adr;

    // Source memory contents: a fixed scramble of the address.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h5A;
    endfunction

    assign bus_data = src_byte(dma_adr);

    lr35902_oam_dma #(.LEN(LEN), .REG_ADR(16'hFF46)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .cpu_adr(cpu_adr), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .dma_reg(dma_reg), .dma_active(dma_active), .bus_dma(bus_dma),
        .dma_adr(dma_adr), .bus_data(bus_data),
        .oam_adr(oam_adr), .oam_wdata(oam_wdata), .oam_we(oam_we),
        .cpu_block(cpu_block)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a transfer is "active" and has seen m_ces ce strobes
    // since the start write; 0 means the startup cycle, k>0 means byte k-1.
    bit         m_active = 1'b0;
    int         m_ces    = 0;
    logic [7:0] m_page   = 8'h00;
    logic [7:0] m_reg    = 8'h00;

    int         we_cnt = 0;
    logic [8:0] oam_mem [256];
    logic       last_we;

    typedef struct {
        logic [15:0] adr;
        logic        blk;
    } blk_vec_t;
    blk_vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic c, input logic wr,
                       input logic [15:0] adr, input logic [7:0] din);
        bit          xfer, regwr;
        logic [15:0] e_adr;
        logic [43:0] e, a;
        @(posedge clk); #1;
        reset = rst; ce = c; cpu_wr = wr; cpu_adr = adr; cpu_din = din;
        @(negedge clk);
        regwr = wr && (adr == 16'hFF46);
        xfer  = m_active && (m_ces > 0);
        e_adr = xfer ? {m_page, 8'(m_ces - 1)} : 16'h0000;
        e = {m_active, xfer, xfer && (adr < 16'hFF00), c && xfer && !regwr,
             m_reg, e_adr, e_adr[7:0] & {8{xfer}}, src_byte(e_adr)};
        a = {dma_active, bus_dma, cpu_block, oam_we, dma_reg, dma_adr, oam_adr, oam_wdata};
        chk("cycle", 64'(a), 64'(e));
        last_we = oam_we;
        if (oam_we) begin
            we_cnt++;
            oam_mem[oam_adr] = {1'b0, oam_wdata};
        end
        // Advance the model across the coming clock edge.
        if (rst) begin
            m_active = 1'b0; m_ces = 0; m_page = 8'h00; m_reg = 8'h00;
        end else if (regwr) begin
            m_reg    = din;
            m_page   = (din >= 8'hE0) ? din - 8'h20 : din;
            m_active = 1'b1;
            m_ces    = 0;
        end else if (c && m_active) begin
            m_ces++;
            if (m_ces == LEN + 1) begin
                m_active = 1'b0;
                m_ces    = 0;
            end
        end
    endtask

    task automatic write_reg(input logic [7:0] v);
        cyc(1'b0, 1'b0, 1'b1, 16'hFF46, v);
    endtask

    task automatic run_to_idle(input int period);
        int n = 0;
        while (m_active && n < 3000) begin
            cyc(1'b0, (n % period) == period - 1, 1'b0, 16'($urandom), 8'h00);
            n++;
        end
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk("idle_reached", 64'(dma_active), 64'(0));
    endtask

    task automatic run_until_ces(input int target, input int period);
        int n = 0;
        while (m_ces != target && n < 3000) begin
            cyc(1'b0, (n % period) == period - 1, 1'b0, 16'($urandom), 8'h00);
            n++;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) oam_mem[i] = 9'h100;
    endtask

    task automatic check_mem(input logic [7:0] page);
        int bad = 0;
        for (int i = 0; i < LEN; i++)
            if (oam_mem[i] !== {1'b0, src_byte({page, 8'(i)})}) bad++;
        chk("oam_contents", 64'(bad), 64'(0));
    endtask

    initial begin
        tbl[0] = '{16'hC000, 1'b1};
        tbl[1] = '{16'hFE10, 1'b1};
        tbl[2] = '{16'hFF80, 1'b0};
        tbl[3] = '{16'hFF46, 1'b0};
        tbl[4] = '{16'hFEFF, 1'b1};
        tbl[5] = '{16'hFF00, 1'b0};
        tbl[6] = '{16'h0000, 1'b1};

        reset = 1'b1; ce = 1'b0; cpu_wr = 1'b0; cpu_adr = 16'h0000; cpu_din = 8'h00;
        last_we = 1'b0;
        clear_mem();

        // Reset, including reset coinciding with a register write.
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        cyc(1'b1, 1'b1, 1'b1, 16'hFF46, 8'hAB);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk("reset_active", 64'(dma_active), 64'(0));
        chk("reset_reg", 64'(dma_reg), 64'(0));

        // Basic transfer, ce every 4 clk.
        we_cnt = 0;
        write_reg(8'hC1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk("active_after_write", 64'({dma_active, bus_dma}), 64'(2'b10));
        run_to_idle(4);
        chk("we_count_c1", 64'(we_cnt), 64'(160));
        check_mem(8'hC1);
        chk("dma_reg_c1", 64'(dma_reg), 64'(8'hC1));

        // Echo alias source.
        clear_mem(); we_cnt = 0;
        write_reg(8'hE3);
        run_to_idle(3);
        chk("we_count_e3", 64'(we_cnt), 64'(160));
        check_mem(8'hC3);
        chk("dma_reg_e3", 64'(dma_reg), 64'(8'hE3));

        // Restart after 50 bytes with the write landing on a ce.
        we_cnt = 0;
        write_reg(8'h80);
        run_until_ces(51, 2);
        chk("we_before_restart", 64'(we_cnt), 64'(50));
        clear_mem(); we_cnt = 0;
        cyc(1'b0, 1'b1, 1'b1, 16'hFF46, 8'h90);
        chk("restart_we_suppressed", 64'(last_we), 64'(0));
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk("restart_in_start", 64'({dma_active, bus_dma}), 64'(2'b10));
        run_to_idle(2);
        chk("we_count_restart", 64'(we_cnt), 64'(160));
        check_mem(8'h90);

        // cpu_block: START, XFER and IDLE against the vector table.
        write_reg(8'hC0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 1'b0, tbl[i].adr, 8'h00);
            chk("blk_start", 64'(cpu_block), 64'(0));
        end
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 1'b0, tbl[i].adr, 8'h00);
            chk("blk_xfer", 64'(cpu_block), 64'(tbl[i].blk));
        end
        run_to_idle(3);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 1'b0, tbl[i].adr, 8'h00);
            chk("blk_idle", 64'(cpu_block), 64'(0));
        end

        // Reset at byte 100 aborts the transfer.
        we_cnt = 0;
        write_reg(8'hA0);
        run_until_ces(101, 2);
        chk("we_before_reset", 64'(we_cnt), 64'(100));
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk("abort_state", 64'({dma_active, oam_we, dma_reg}), 64'(0));
        we_cnt = 0;
        for (int i = 0; i < 400; i++) cyc(1'b0, i[0], 1'b0, 16'($urandom), 8'h00);
        chk("no_writes_after_reset", 64'(we_cnt), 64'(0));
        cyc(1'b1, 1'b0, 1'b1, 16'hFF46, 8'h55);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk("reset_beats_write", 64'({dma_active, dma_reg}), 64'(0));

        // ce stall mid-transfer.
        clear_mem(); we_cnt = 0;
        write_reg(8'h42);
        run_until_ces(31, 2);
        chk("we_before_stall", 64'(we_cnt), 64'(30));
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 16'($urandom), 8'h00);
        chk("we_during_stall", 64'(we_cnt), 64'(30));
        run_to_idle(2);
        chk("we_count_stall", 64'(we_cnt), 64'(160));
        check_mem(8'h42);

        // Randomized traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            logic        r_rst, r_wr;
            logic [15:0] r_adr;
            r_rst = ($urandom_range(0, 599) == 0);
            r_wr  = ($urandom_range(0, 29) == 0);
            r_adr = ($urandom_range(0, 9) == 0) ? 16'hFF46 : 16'($urandom);
            if (r_wr && $urandom_range(0, 3) != 0) r_adr = 16'h0123;
            cyc(r_rst, $urandom_range(0, 2) == 0, r_wr, r_adr, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lr35902_oam_dma.md
Name: lr35902_oam_dma

Overview:
- OAM DMA controller for the LR35902 system bus.
- A CPU write to the DMA register (0xFF46) starts a copy of LEN bytes from {src,8'h00} into OAM at 0xFE00.
- Moves one byte per machine cycle (ce strobe) and tells the bus mux when DMA owns the bus.
- Tells the CPU side which accesses are blocked while a transfer runs.
- Sits beside the address decoder. dma_adr feeds the decoder whenever bus_dma=1.

Parameters:
- LEN, 160, bytes per transfer (OAM size). Legal range 1..256.
- REG_ADR, 16'hFF46, address of the DMA start/source register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  one-clk strobe per machine cycle; paces the transfer
- cpu_adr  in  16  CPU bus address
- cpu_wr  in  1  CPU write strobe; single clk pulse per write
- cpu_din  in  8  CPU write data
- dma_reg  out  8  last value written to REG_ADR; drives readback
- dma_active  out  1  transfer pending or running (START or XFER)
- bus_dma  out  1  DMA owns the source bus (XFER only)
- dma_adr  out  16  source address for the current byte
- bus_data  in  8  data returned from the source at dma_adr
- oam_adr  out  8  OAM byte index being written
- oam_wdata  out  8  OAM write data
- oam_we  out  1  OAM write strobe
- cpu_block  out  1  current CPU access must be ignored and reads return 8'hFF

Behaviour:
- Reset values: state=IDLE, idx=0, src=8'h00, dma_reg=8'h00. All strobes and flags 0. dma_adr=16'h0000. oam_adr=0.
- Reset wins over every other event in the same clk, including a cpu_wr to REG_ADR. Reset mid-transfer aborts; no further oam_we.
- Register write: cpu_wr && cpu_adr==REG_ADR, evaluated every clk, independent of ce. Effects:
  - dma_reg <= cpu_din.
  - src <= cpu_din>=8'hE0 ? cpu_din & 8'hDF : cpu_din (0xE0-0xFF alias to WRAM 0xC0-0xDF).
  - idx <= 0; state <= START.
  - Applies in any state, so a write during START or XFER restarts the transfer.
- States:
  - IDLE: waits for a register write.
  - START: one machine cycle of startup delay. At the next ce edge it goes to XFER with idx=0.
  - XFER: one byte per ce.
- XFER datapath:
  - dma_adr = {src, idx}.
  - oam_adr = idx.
  - oam_wdata = bus_data (combinational pass-through).
  - oam_we = ce && state==XFER && !reg_write_this_clk.
  - At that ce edge idx increments. If idx==LEN-1, state <= IDLE and idx <= 0.
  - A register write coinciding with an XFER ce suppresses that oam_we; the restart takes effect.
- Latency: write at clk T, first ce after T ends START, the following ce performs the first OAM write. The last byte is written on the (LEN+1)th ce after the write.
- Outputs:
  - dma_active = state!=IDLE.
  - bus_dma = state==XFER.
  - cpu_block = state==XFER && cpu_adr<16'hFF00. The I/O and HRAM region stays accessible, including REG_ADR for restart.
  - dma_adr = 0 and oam_adr = 0 outside XFER.
- idx is 8 bits, and LEN<=256 guarantees no wrap. When LEN==256 the terminal compare uses idx==8'hFF.
- ce held low freezes the state machine; no timeout.

Decomposition:
- Shared package lr35902_pkg:
  - dma_state_t enum (IDLE, START, XFER)
  - DMA_REG_ADR=16'hFF46
  - OAM_BASE=16'hFE00
  - OAM_LEN=160
  - HRAM_IO_BASE=16'hFF00
  - DMA_ECHO_MASK=8'hDF
- No sub-module is needed. The counter and FSM are a single module.

Test Plan:
- Write 8'hC1 to 0xFF46, ce every 4 clk:
  - dma_active rises next clk; bus_dma rises after 1st ce.
  - oam_we fires 160 times with dma_adr 0xC100..0xC19F and oam_adr 0..159.
  - Idle after the 161st ce; dma_reg=8'hC1.
- Source alias: write 8'hE3 -> dma_adr runs 0xC300..0xC39F; dma_reg reads 8'hE3.
- Restart: write 8'h80, then after 50 bytes write 8'h90 in the same clk as a ce:
  - No oam_we in that clk; START is re-entered.
  - Then 160 writes from 0x9000 with oam_adr starting at 0.
- cpu_block during XFER: cpu_adr=0xC000 -> 1, 0xFE10 -> 1, 0xFF80 -> 0, 0xFF46 -> 0. In START or IDLE all give 0.
- Reset at byte 100: next clk is IDLE, oam_we=0, dma_reg=0, and no further writes. Reset asserted together with cpu_wr to 0xFF46 -> stays IDLE.
- ce stall: hold ce low for 20 clk mid-XFER -> idx, dma_adr and oam_adr hold, and no oam_we. Resuming completes the exact remaining count.
